// File: rtl/ori_hist_peak.sv
// Orientation histogram peak finder: accumulates 256 gradient magnitudes into 32
// saturating orientation bins, then scans the bins for the dominant orientation.
module ori_hist_peak #(
  parameter int MAG_W = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] in_mag,
  output logic [7:0]       rom_a,
  input  logic [4:0]       rom_spo,
  output logic             pk_valid,
  input  logic             pk_ready,
  output logic [4:0]       pk_bin,
  output logic [ACC_W-1:0] pk_val,
  output logic             busy
);

  // state   | meaning
  // S_ACCUM | accept samples, bin[rom_spo] += in_mag, pos advances
  // S_SCAN  | walk bins 0..31, track strict max, clear each bin read
  // S_OUT   | hold result until pk_ready
  typedef enum logic [1:0] {S_ACCUM, S_SCAN, S_OUT} state_t;

  localparam int SUM_W = ACC_W + 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_bin [32];
  logic [7:0]       r_pos;
  logic [4:0]       r_idx;
  logic [ACC_W-1:0] r_max;
  logic [4:0]       r_max_idx;
  logic [4:0]       r_pk_bin;
  logic [ACC_W-1:0] r_pk_val;

  logic             w_accept;
  logic [SUM_W-1:0] w_sum;
  logic [ACC_W-1:0] w_acc_sat;
  logic [ACC_W-1:0] w_cand;
  logic             w_gt;
  logic             w_scan_last;

  assign w_accept    = in_valid && (r_state == S_ACCUM);
  assign w_sum       = {1'b0, r_bin[rom_spo]} + SUM_W'(in_mag);
  assign w_acc_sat   = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
  assign w_cand      = r_bin[r_idx];
  assign w_gt        = w_cand > r_max;
  assign w_scan_last = (r_idx == 5'd31);

  assign in_ready = (r_state == S_ACCUM);
  assign busy     = (r_state != S_ACCUM);
  assign pk_valid = (r_state == S_OUT);
  assign rom_a    = r_pos;
  assign pk_bin   = r_pk_bin;
  assign pk_val   = r_pk_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_ACCUM;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACCUM: if (w_accept && (r_pos == 8'hFF)) w_state_nxt = S_SCAN;
      S_SCAN:  if (w_scan_last)                  w_state_nxt = S_OUT;
      S_OUT:   if (pk_ready)                     w_state_nxt = S_ACCUM;
      default:                                   w_state_nxt = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_bin[i] <= '0;
      r_pos     <= '0;
      r_idx     <= '0;
      r_max     <= '0;
      r_max_idx <= '0;
      r_pk_bin  <= '0;
      r_pk_val  <= '0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (w_accept) begin
            r_bin[rom_spo] <= w_acc_sat;
            r_pos          <= r_pos + 8'd1;
          end
        end
        S_SCAN: begin
          r_bin[r_idx] <= '0;
          r_idx        <= r_idx + 5'd1;
          if (w_scan_last) begin
            // last candidate folds straight into the result; max is re-armed for next frame
            r_pk_val  <= w_gt ? w_cand : r_max;
            r_pk_bin  <= w_gt ? r_idx  : r_max_idx;
            r_max     <= '0;
            r_max_idx <= '0;
          end else if (w_gt) begin
            r_max     <= w_cand;
            r_max_idx <= r_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ori_hist_peak.sv
// Self-checking bench for ori_hist_peak: directed spec scenarios plus randomized
// frames checked against a plain-arithmetic histogram model.
module tb_ori_hist_peak;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, pk_ready, sel;
  logic [7:0]  in_mag;
  logic        in_ready16, in_ready12, pk_valid16, pk_valid12, busy16, busy12;
  logic [7:0]  rom_a16, rom_a12;
  logic [4:0]  rom_spo16, rom_spo12, pk_bin16, pk_bin12;
  logic [15:0] pk_val16;
  logic [11:0] pk_val12;

  int          rom_mode;
  logic [4:0]  rom_const;
  logic [4:0]  rom_tbl [256];
  int          fr_mag  [256];
  int          n_tests = 0;
  int          n_fail  = 0;

  always_comb begin
    case (rom_mode)
      0:       rom_spo16 = rom_const;
      1:       rom_spo16 = {4'b0, rom_a16[0]};
      default: rom_spo16 = rom_tbl[rom_a16];
    endcase
  end

  always_comb begin
    case (rom_mode)
      0:       rom_spo12 = rom_const;
      1:       rom_spo12 = {4'b0, rom_a12[0]};
      default: rom_spo12 = rom_tbl[rom_a12];
    endcase
  end

  ori_hist_peak #(.MAG_W(8), .ACC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(in_ready16),
    .in_mag(in_mag), .rom_a(rom_a16), .rom_spo(rom_spo16), .pk_valid(pk_valid16),
    .pk_ready(pk_ready & ~sel), .pk_bin(pk_bin16), .pk_val(pk_val16), .busy(busy16)
  );

  ori_hist_peak #(.MAG_W(8), .ACC_W(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(in_ready12),
    .in_mag(in_mag), .rom_a(rom_a12), .rom_spo(rom_spo12), .pk_valid(pk_valid12),
    .pk_ready(pk_ready & sel), .pk_bin(pk_bin12), .pk_val(pk_val12), .busy(busy12)
  );

  logic       cur_ready, cur_pk_valid;
  logic [7:0] cur_rom_a;
  assign cur_ready    = sel ? in_ready12  : in_ready16;
  assign cur_pk_valid = sel ? pk_valid12  : pk_valid16;
  assign cur_rom_a    = sel ? rom_a12     : rom_a16;

  function automatic int rom_fn(input int p);
    case (rom_mode)
      0:       return int'(rom_const);
      1:       return p % 2;
      default: return int'(rom_tbl[p]);
    endcase
  endfunction

  // Histogram over the frame from the orientation rule, then the lowest bin holding the maximum.
  task automatic model(input int accw, output int eb, output longint ev);
    longint b [32];
    longint cap;
    int     k;
    cap = (longint'(1) << accw) - 1;
    for (int i = 0; i < 32; i++) b[i] = 0;
    for (int p = 0; p < 256; p++) begin
      k = rom_fn(p);
      b[k] = (b[k] + fr_mag[p] > cap) ? cap : b[k] + fr_mag[p];
    end
    ev = 0;
    for (int i = 0; i < 32; i++) if (b[i] > ev) ev = b[i];
    eb = 0;
    for (int i = 31; i >= 0; i--) if (b[i] == ev) eb = i;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic ack();
    pk_ready = 1'b1;
    @(posedge clk); #1;
    pk_ready = 1'b0;
  endtask

  task automatic fill(input int v);
    for (int p = 0; p < 256; p++) fr_mag[p] = v;
  endtask

  // Streams fr_mag as one frame; lat counts edges from the last accept to pk_valid.
  task automatic run_frame(input int gap_pct, output int lat);
    int bad_p;
    bad_p = -1;
    for (int p = 0; p < 256; p++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_mag   = 8'(fr_mag[p]);
      if ((cur_rom_a !== 8'(p) || cur_ready !== 1'b1) && bad_p < 0) bad_p = p;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_tests++;
    if (bad_p >= 0) begin
      n_fail++;
      $display("FAIL frame_pos first bad position=%0d, rom_a/in_ready did not track pos with in_ready=1", bad_p);
    end
    lat = 0;
    while (cur_pk_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (in_ready16 !== 1'b1 || rom_a16 !== 8'h00 || pk_valid16 !== 1'b0 || busy16 !== 1'b0 ||
        pk_bin16 !== 5'd0 || pk_val16 !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state got ready=%b rom_a=%h pk_valid=%b busy=%b pk_bin=%0d pk_val=%0d, expected 1 00 0 0 0 0",
               in_ready16, rom_a16, pk_valid16, busy16, pk_bin16, pk_val16);
    end
  endtask

  task automatic test_const(input string nm);
    int lat;
    rom_mode = 0; rom_const = 5'h03; fill(2);
    run_frame(0, lat);
    n_tests++;
    if (lat !== 32) begin
      n_fail++; $display("FAIL %s_latency got %0d expected 32", nm, lat);
    end
    n_tests++;
    if (pk_bin16 !== 5'd3 || pk_val16 !== 16'd512) begin
      n_fail++; $display("FAIL %s_peak got bin=%0d val=%0d expected bin=3 val=512", nm, pk_bin16, pk_val16);
    end
    ack();
  endtask

  task automatic test_tie();
    int lat;
    rom_mode = 1; fill(5);
    run_frame(10, lat);
    n_tests++;
    if (pk_bin16 !== 5'd0 || pk_val16 !== 16'd640 || lat !== 32) begin
      n_fail++; $display("FAIL tie_low got bin=%0d val=%0d lat=%0d expected bin=0 val=640 lat=32", pk_bin16, pk_val16, lat);
    end
    ack();
  endtask

  task automatic test_sat();
    int lat;
    sel = 1'b1; rom_mode = 0; rom_const = 5'h07; fill(255);
    run_frame(0, lat);
    n_tests++;
    if (pk_bin12 !== 5'd7 || pk_val12 !== 12'hFFF || lat !== 32) begin
      n_fail++; $display("FAIL saturate got bin=%0d val=%h lat=%0d expected bin=7 val=fff lat=32", pk_bin12, pk_val12, lat);
    end
    ack();
    sel = 1'b0;
  endtask

  task automatic test_zero();
    int lat;
    rom_mode = 2;
    for (int p = 0; p < 256; p++) rom_tbl[p] = 5'($urandom_range(31));
    fill(0);
    run_frame(0, lat);
    n_tests++;
    if (pk_bin16 !== 5'd0 || pk_val16 !== 16'd0 || lat !== 32) begin
      n_fail++; $display("FAIL all_zero got bin=%0d val=%0d lat=%0d expected 0 0 32", pk_bin16, pk_val16, lat);
    end
    ack();
  endtask

  task automatic test_random();
    int     lat, eb;
    longint ev;
    rom_mode = 2;
    for (int f = 0; f < 5; f++) begin
      for (int p = 0; p < 256; p++) begin
        rom_tbl[p] = 5'((f % 2 == 0) ? $urandom_range(31) : $urandom_range(7) * 4);
        fr_mag[p]  = (f == 3) ? int'($urandom_range(3)) : int'($urandom_range(255));
      end
      model(16, eb, ev);
      run_frame(25, lat);
      n_tests++;
      if (pk_bin16 !== 5'(eb) || pk_val16 !== 16'(ev) || lat !== 32) begin
        n_fail++;
        $display("FAIL random_frame%0d got bin=%0d val=%0d lat=%0d expected bin=%0d val=%0d lat=32",
                 f, pk_bin16, pk_val16, lat, eb, ev);
      end
      ack();
    end
  endtask

  task automatic test_hold();
    int       lat, bad;
    logic [4:0]  b0;
    logic [15:0] v0;
    rom_mode = 0; rom_const = 5'h03; fill(2);
    run_frame(0, lat);
    b0 = pk_bin16; v0 = pk_val16;
    in_valid = 1'b1; in_mag = 8'd9;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (pk_valid16 !== 1'b1 || pk_bin16 !== b0 || pk_val16 !== v0 || in_ready16 !== 1'b0 ||
          rom_a16 !== 8'h00 || busy16 !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (bad != 0 || b0 !== 5'd3 || v0 !== 16'd512) begin
      n_fail++; $display("FAIL hold_out got %0d unstable cycles, bin=%0d val=%0d, expected 0 unstable, bin=3 val=512", bad, b0, v0);
    end
    ack();
    n_tests++;
    if (pk_valid16 !== 1'b0 || in_ready16 !== 1'b1 || rom_a16 !== 8'h00 || busy16 !== 1'b0) begin
      n_fail++; $display("FAIL after_ack got pk_valid=%b ready=%b rom_a=%h busy=%b expected 0 1 00 0",
                         pk_valid16, in_ready16, rom_a16, busy16);
    end
    test_const("repeat");
  endtask

  task automatic test_reset_mid();
    int lat;
    rom_mode = 0; rom_const = 5'h03;
    in_valid = 1'b1; in_mag = 8'd2;
    repeat (100) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    rst_n = 1'b0; #2;
    n_tests++;
    if (rom_a16 !== 8'h00 || in_ready16 !== 1'b1 || busy16 !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_frame got rom_a=%h ready=%b busy=%b expected 00 1 0", rom_a16, in_ready16, busy16);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    test_const("after_reset");
    // Frame into bin 20 is reset mid-scan before bin 20 is visited; leftovers would win the next frame.
    rom_const = 5'd20; in_valid = 1'b1; in_mag = 8'd2;
    repeat (256) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    n_tests++;
    if (busy16 !== 1'b1) begin
      n_fail++; $display("FAIL in_scan got busy=%b expected 1", busy16);
    end
    rst_n = 1'b0; #2;
    n_tests++;
    if (busy16 !== 1'b0 || pk_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_scan got busy=%b pk_valid=%b ready=%b expected 0 0 1", busy16, pk_valid16, in_ready16);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    rom_const = 5'd25; fill(1);
    run_frame(0, lat);
    n_tests++;
    if (pk_bin16 !== 5'd25 || pk_val16 !== 16'd256 || lat !== 32) begin
      n_fail++; $display("FAIL scan_reset_clear got bin=%0d val=%0d lat=%0d expected bin=25 val=256 lat=32", pk_bin16, pk_val16, lat);
    end
    ack();
  endtask

  initial begin
    in_valid = 1'b0; pk_ready = 1'b0; sel = 1'b0; in_mag = '0;
    rom_mode = 0; rom_const = '0;
    for (int p = 0; p < 256; p++) rom_tbl[p] = '0;
    do_reset();
    test_reset();
    test_const("const");
    test_tie();
    test_sat();
    test_zero();
    test_random();
    test_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
